// File: rtl/execute_stage_pkg.sv
// Shared constants for the MIPS execute stage: ALU opcodes, forward selects and the link register index.
package execute_stage_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_REG_DEF  = 5;
    localparam int NB_OP_DEF   = 4;

    localparam logic [NB_OP_DEF-1:0] ALU_ADD  = 4'd0;
    localparam logic [NB_OP_DEF-1:0] ALU_SUB  = 4'd1;
    localparam logic [NB_OP_DEF-1:0] ALU_AND  = 4'd2;
    localparam logic [NB_OP_DEF-1:0] ALU_OR   = 4'd3;
    localparam logic [NB_OP_DEF-1:0] ALU_XOR  = 4'd4;
    localparam logic [NB_OP_DEF-1:0] ALU_NOR  = 4'd5;
    localparam logic [NB_OP_DEF-1:0] ALU_SLT  = 4'd6;
    localparam logic [NB_OP_DEF-1:0] ALU_SLTU = 4'd7;
    localparam logic [NB_OP_DEF-1:0] ALU_SLL  = 4'd8;
    localparam logic [NB_OP_DEF-1:0] ALU_SRL  = 4'd9;
    localparam logic [NB_OP_DEF-1:0] ALU_SRA  = 4'd10;
    localparam logic [NB_OP_DEF-1:0] ALU_SLLV = 4'd11;
    localparam logic [NB_OP_DEF-1:0] ALU_SRLV = 4'd12;
    localparam logic [NB_OP_DEF-1:0] ALU_SRAV = 4'd13;
    localparam logic [NB_OP_DEF-1:0] ALU_LUI  = 4'd14;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [NB_REG_DEF-1:0] REG_RA = 5'd31;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one interface.
interface execute_stage_if
    import execute_stage_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_OP   = NB_OP_DEF
);
    logic [NB_DATA-1:0] i_rs_data;
    logic [NB_DATA-1:0] i_rt_data;
    logic [NB_DATA-1:0] i_imm;
    logic [4:0]         i_shamt;
    logic [NB_REG-1:0]  i_rt_addr;
    logic [NB_REG-1:0]  i_rd_addr;
    logic [NB_DATA-1:0] i_pc8;
    logic [NB_OP-1:0]   i_alu_ctrl;
    logic               i_alu_src;
    logic               i_reg_dst;
    logic               i_link;
    logic               i_link_ra;
    logic [1:0]         i_fwd_a;
    logic [1:0]         i_fwd_b;
    logic [NB_DATA-1:0] i_exmem_fwd;
    logic [NB_DATA-1:0] i_memwb_fwd;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic               i_mem2reg;
    logic               i_memWrite;
    logic               i_regWrite;

    logic [NB_DATA-1:0] o_result;
    logic [NB_DATA-1:0] o_data4Mem;
    logic [NB_REG-1:0]  o_write_reg;
    logic [1:0]         o_width;
    logic               o_sign_flag;
    logic               o_mem2reg;
    logic               o_memWrite;
    logic               o_regWrite;

    modport master (
        output i_rs_data, i_rt_data, i_imm, i_shamt, i_rt_addr, i_rd_addr, i_pc8,
               i_alu_ctrl, i_alu_src, i_reg_dst, i_link, i_link_ra, i_fwd_a, i_fwd_b,
               i_exmem_fwd, i_memwb_fwd, i_width, i_sign_flag, i_mem2reg, i_memWrite, i_regWrite,
        input  o_result, o_data4Mem, o_write_reg, o_width, o_sign_flag, o_mem2reg,
               o_memWrite, o_regWrite
    );

    modport slave (
        input  i_rs_data, i_rt_data, i_imm, i_shamt, i_rt_addr, i_rd_addr, i_pc8,
               i_alu_ctrl, i_alu_src, i_reg_dst, i_link, i_link_ra, i_fwd_a, i_fwd_b,
               i_exmem_fwd, i_memwb_fwd, i_width, i_sign_flag, i_mem2reg, i_memWrite, i_regWrite,
        output o_result, o_data4Mem, o_write_reg, o_width, o_sign_flag, o_mem2reg,
               o_memWrite, o_regWrite
    );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational MIPS ALU: arithmetic, logic, compares, shifts and LUI.
module alu
    import execute_stage_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [4:0]         shamt,
    input  logic [NB_OP-1:0]   ctrl,
    output logic [NB_DATA-1:0] result
);
    // Variable shifts take only the low five bits of A
    logic [4:0] shamt_v;
    assign shamt_v = a[4:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(NB_DATA-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(NB_DATA-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = NB_DATA'($signed(b) >>> shamt);
            ALU_SLLV: result = b << shamt_v;
            ALU_SRLV: result = b >> shamt_v;
            ALU_SRAV: result = NB_DATA'($signed(b) >>> shamt_v);
            ALU_LUI:  result = {b[NB_DATA-17:0], 16'h0000};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding muxes, ALU, destination select and the EX/MEM pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_REG  = NB_REG_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_halt,
    input  logic                 i_flush,
    execute_stage_if.slave       bus
);
    logic [NB_DATA-1:0] fwd_a;
    logic [NB_DATA-1:0] fwd_b;
    logic [NB_DATA-1:0] op_b;
    logic [NB_DATA-1:0] alu_out;
    logic [NB_DATA-1:0] result_d;
    logic [NB_REG-1:0]  dest_d;
    logic [NB_OP-1:0]   alu_ctrl;

    // Select 11 falls back to the register value, same as 00
    always_comb begin
        case (bus.i_fwd_a)
            FWD_MEMWB: fwd_a = bus.i_memwb_fwd;
            FWD_EXMEM: fwd_a = bus.i_exmem_fwd;
            default:   fwd_a = bus.i_rs_data;
        endcase
        case (bus.i_fwd_b)
            FWD_MEMWB: fwd_b = bus.i_memwb_fwd;
            FWD_EXMEM: fwd_b = bus.i_exmem_fwd;
            default:   fwd_b = bus.i_rt_data;
        endcase
    end

    assign op_b     = bus.i_alu_src ? bus.i_imm : fwd_b;
    assign alu_ctrl = bus.i_alu_ctrl;

    alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .a      (fwd_a),
        .b      (op_b),
        .shamt  (bus.i_shamt),
        .ctrl   (alu_ctrl),
        .result (alu_out)
    );

    assign result_d = bus.i_link ? bus.i_pc8 : alu_out;
    assign dest_d   = bus.i_link_ra ? REG_RA
                    : (bus.i_reg_dst ? bus.i_rd_addr : bus.i_rt_addr);

    // Halt outranks flush so a stalled bubble request cannot drop a held instruction
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_result    <= '0;
            bus.o_data4Mem  <= '0;
            bus.o_write_reg <= '0;
            bus.o_width     <= '0;
            bus.o_sign_flag <= 1'b0;
            bus.o_mem2reg   <= 1'b0;
            bus.o_memWrite  <= 1'b0;
            bus.o_regWrite  <= 1'b0;
        end else if (i_halt) begin
            bus.o_result    <= bus.o_result;
            bus.o_data4Mem  <= bus.o_data4Mem;
            bus.o_write_reg <= bus.o_write_reg;
            bus.o_width     <= bus.o_width;
            bus.o_sign_flag <= bus.o_sign_flag;
            bus.o_mem2reg   <= bus.o_mem2reg;
            bus.o_memWrite  <= bus.o_memWrite;
            bus.o_regWrite  <= bus.o_regWrite;
        end else if (i_flush) begin
            bus.o_result    <= '0;
            bus.o_data4Mem  <= '0;
            bus.o_write_reg <= '0;
            bus.o_width     <= '0;
            bus.o_sign_flag <= 1'b0;
            bus.o_mem2reg   <= 1'b0;
            bus.o_memWrite  <= 1'b0;
            bus.o_regWrite  <= 1'b0;
        end else begin
            bus.o_result    <= result_d;
            bus.o_data4Mem  <= fwd_b;
            bus.o_write_reg <= dest_d;
            bus.o_width     <= bus.i_width;
            bus.o_sign_flag <= bus.i_sign_flag;
            bus.o_mem2reg   <= bus.i_mem2reg;
            bus.o_memWrite  <= bus.i_memWrite;
            bus.o_regWrite  <= bus.i_regWrite;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for the datapath plus halt/flush/reset sequences.
module tb_execute_stage;
    import execute_stage_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] rs, rt, imm, pc8, exmem, memwb;
        logic [4:0]  shamt, rt_addr, rd_addr;
        logic [3:0]  ctrl;
        logic        alu_src, reg_dst, link, link_ra;
        logic [1:0]  fwd_a, fwd_b;
        logic [5:0]  ctl;        // {width, sign_flag, mem2reg, memWrite, regWrite}
        logic [31:0] exp_result, exp_data;
        logic [4:0]  exp_reg;
    } vec_t;

    logic clk;
    logic i_rst_n;
    logic i_halt;
    logic i_flush;
    int   n_tests;
    int   n_fail;

    execute_stage_if bus ();

    execute_stage dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_halt  (i_halt),
        .i_flush (i_flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t blank(input string nm);
        vec_t t;
        t.name = nm;
        t.rs = '0; t.rt = '0; t.imm = '0; t.pc8 = '0; t.exmem = '0; t.memwb = '0;
        t.shamt = '0; t.rt_addr = 5'd3; t.rd_addr = 5'd9; t.ctrl = ALU_ADD;
        t.alu_src = 1'b0; t.reg_dst = 1'b0; t.link = 1'b0; t.link_ra = 1'b0;
        t.fwd_a = FWD_REG; t.fwd_b = FWD_REG; t.ctl = 6'b000001;
        t.exp_result = '0; t.exp_data = '0; t.exp_reg = 5'd3;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] out_ctl();
        return {bus.o_width, bus.o_sign_flag, bus.o_mem2reg, bus.o_memWrite, bus.o_regWrite};
    endfunction

    task automatic drive(input vec_t t);
        bus.i_rs_data   = t.rs;      bus.i_rt_data   = t.rt;
        bus.i_imm       = t.imm;     bus.i_shamt     = t.shamt;
        bus.i_rt_addr   = t.rt_addr; bus.i_rd_addr   = t.rd_addr;
        bus.i_pc8       = t.pc8;     bus.i_alu_ctrl  = t.ctrl;
        bus.i_alu_src   = t.alu_src; bus.i_reg_dst   = t.reg_dst;
        bus.i_link      = t.link;    bus.i_link_ra   = t.link_ra;
        bus.i_fwd_a     = t.fwd_a;   bus.i_fwd_b     = t.fwd_b;
        bus.i_exmem_fwd = t.exmem;   bus.i_memwb_fwd = t.memwb;
        {bus.i_width, bus.i_sign_flag, bus.i_mem2reg, bus.i_memWrite, bus.i_regWrite} = t.ctl;
    endtask

    task automatic check_out(input string nm, input logic [31:0] r, input logic [31:0] d,
                             input logic [4:0] w, input logic [5:0] c);
        check({nm, ".result"}, bus.o_result, r);
        check({nm, ".data4Mem"}, bus.o_data4Mem, d);
        check({nm, ".write_reg"}, {27'd0, bus.o_write_reg}, {27'd0, w});
        check({nm, ".ctl"}, {26'd0, out_ctl()}, {26'd0, c});
    endtask

    task automatic run_vec(input vec_t t);
        drive(t);
        @(posedge clk);
        @(negedge clk);
        check_out(t.name, t.exp_result, t.exp_data, t.exp_reg, t.ctl);
    endtask

    vec_t v[$];
    vec_t t;
    vec_t jal;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_halt  = 1'b0;
        i_flush = 1'b0;
        i_rst_n = 1'b0;
        drive(blank("idle"));

        t = blank("add_fwd_exmem"); t.fwd_a = FWD_EXMEM; t.exmem = 32'd5; t.rt = 32'd7;
        t.reg_dst = 1'b1; t.exp_result = 32'd12; t.exp_data = 32'd7; t.exp_reg = 5'd9; v.push_back(t);
        t = blank("slt"); t.rs = 32'hFFFF_FFFF; t.rt = 32'd1; t.ctrl = ALU_SLT; t.rt_addr = 5'd4;
        t.exp_result = 32'd1; t.exp_data = 32'd1; t.exp_reg = 5'd4; v.push_back(t);
        t.name = "sltu"; t.ctrl = ALU_SLTU; t.exp_result = 32'd0; v.push_back(t);
        t = blank("sra"); t.rt = 32'h8000_0000; t.shamt = 5'd4; t.ctrl = ALU_SRA;
        t.exp_result = 32'hF800_0000; t.exp_data = 32'h8000_0000; v.push_back(t);
        t = blank("srav"); t.rs = 32'h24; t.rt = 32'h8000_0000; t.ctrl = ALU_SRAV;
        t.exp_result = 32'hF800_0000; t.exp_data = 32'h8000_0000; v.push_back(t);
        t = blank("sw"); t.alu_src = 1'b1; t.imm = 32'd8; t.rs = 32'h10; t.rt = 32'h1111;
        t.fwd_b = FWD_MEMWB; t.memwb = 32'hDEAD; t.ctl = 6'b100010;
        t.exp_result = 32'h18; t.exp_data = 32'hDEAD; v.push_back(t);
        t = blank("sub_wrap"); t.rs = 32'd3; t.rt = 32'd5; t.ctrl = ALU_SUB; t.ctl = 6'b011101;
        t.exp_result = 32'hFFFF_FFFE; t.exp_data = 32'd5; v.push_back(t);
        t = blank("and"); t.rs = 32'hF0F0_00FF; t.rt = 32'h0FF0_0F0F; t.ctrl = ALU_AND;
        t.exp_result = 32'h00F0_000F; t.exp_data = 32'h0FF0_0F0F; v.push_back(t);
        t.name = "or";  t.ctrl = ALU_OR;  t.exp_result = 32'hFFF0_0FFF; v.push_back(t);
        t.name = "xor"; t.ctrl = ALU_XOR; t.exp_result = 32'hFF00_0FF0; v.push_back(t);
        t.name = "nor"; t.ctrl = ALU_NOR; t.exp_result = 32'h000F_F000; v.push_back(t);
        t = blank("sll31"); t.rt = 32'd3; t.shamt = 5'd31; t.ctrl = ALU_SLL;
        t.exp_result = 32'h8000_0000; t.exp_data = 32'd3; v.push_back(t);
        t = blank("srl"); t.rt = 32'h8000_0000; t.shamt = 5'd4; t.ctrl = ALU_SRL;
        t.exp_result = 32'h0800_0000; t.exp_data = 32'h8000_0000; v.push_back(t);
        t = blank("sllv_hi_ignored"); t.rs = 32'hFFFF_FFE1; t.rt = 32'd1; t.ctrl = ALU_SLLV;
        t.exp_result = 32'd2; t.exp_data = 32'd1; v.push_back(t);
        t = blank("srlv_by32_is_0"); t.rs = 32'h20; t.rt = 32'h8000_0000; t.ctrl = ALU_SRLV;
        t.exp_result = 32'h8000_0000; t.exp_data = 32'h8000_0000; v.push_back(t);
        t = blank("lui"); t.alu_src = 1'b1; t.imm = 32'hFFFF_1234; t.rt = 32'h55; t.ctrl = ALU_LUI;
        t.exp_result = 32'h1234_0000; t.exp_data = 32'h55; v.push_back(t);
        t = blank("op15"); t.rs = 32'h7; t.rt = 32'h9; t.ctrl = 4'd15;
        t.exp_result = 32'd0; t.exp_data = 32'h9; v.push_back(t);
        t = blank("fwd11_is_reg"); t.rs = 32'd1; t.rt = 32'd2; t.exmem = 32'd100; t.memwb = 32'd50;
        t.fwd_a = 2'b11; t.fwd_b = 2'b11; t.exp_result = 32'd3; t.exp_data = 32'd2; v.push_back(t);
        t = blank("fwd_b_exmem"); t.rs = 32'd1; t.rt = 32'd2; t.exmem = 32'd100; t.memwb = 32'd50;
        t.fwd_a = FWD_MEMWB; t.fwd_b = FWD_EXMEM; t.exp_result = 32'd150; t.exp_data = 32'd100; v.push_back(t);
        t = blank("jalr"); t.link = 1'b1; t.reg_dst = 1'b1; t.rd_addr = 5'd5; t.pc8 = 32'h80;
        t.rs = 32'd1; t.rt = 32'd1; t.exp_result = 32'h80; t.exp_data = 32'd1; t.exp_reg = 5'd5; v.push_back(t);

        #1;
        check_out("reset", 32'd0, 32'd0, 5'd0, 6'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        foreach (v[i]) run_vec(v[i]);

        // JAL, then a three-cycle halt with different inputs presented
        jal = blank("jal"); jal.link = 1'b1; jal.link_ra = 1'b1; jal.pc8 = 32'h40;
        jal.rs = 32'd6; jal.rt = 32'd7; jal.exp_result = 32'h40; jal.exp_data = 32'd7; jal.exp_reg = 5'd31;
        run_vec(jal);
        i_halt = 1'b1;
        t = blank("other"); t.rs = 32'hAAAA; t.rt = 32'h5555; t.ctl = 6'b110100;
        drive(t);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_out($sformatf("halt%0d", k), 32'h40, 32'd7, 5'd31, 6'b000001);
        end

        // Flush while the register holds a writing instruction
        i_halt  = 1'b0;
        i_flush = 1'b1;
        drive(jal);
        @(posedge clk);
        @(negedge clk);
        check_out("flush", 32'd0, 32'd0, 5'd0, 6'd0);

        i_flush = 1'b0;
        run_vec(jal);
        i_halt  = 1'b1;
        i_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("halt_and_flush", 32'h40, 32'd7, 5'd31, 6'b000001);

        i_halt  = 1'b0;
        i_flush = 1'b0;
        run_vec(v[5]);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_out("async_reset", 32'd0, 32'd0, 5'd0, 6'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        run_vec(v[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, between ID/EX and the memory stage.
- Resolves operand forwarding, selects ALU operands, computes the ALU result and selects the destination register.
- Registers the result, the store data, the destination and the control signals into the EX/MEM pipeline register consumed by the memory stage.
- Supports halt (hold) and flush (bubble insertion).

Parameters:
NB_DATA, 32, datapath width
NB_REG, 5, register-address width
NB_OP, 4, ALU control width

Ports:
clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_halt  input  1  1 = hold the EX/MEM register
i_flush  input  1  1 = load a bubble into the EX/MEM register
i_rs_data  input  NB_DATA  rs value from ID/EX
i_rt_data  input  NB_DATA  rt value from ID/EX
i_imm  input  NB_DATA  sign/zero-extended immediate
i_shamt  input  5  shift amount field
i_rt_addr  input  NB_REG  rt index
i_rd_addr  input  NB_REG  rd index
i_pc8  input  NB_DATA  PC+8 (link value)
i_alu_ctrl  input  NB_OP  ALU operation
i_alu_src  input  1  0 = operand B is rt, 1 = operand B is imm
i_reg_dst  input  1  0 = destination rt, 1 = destination rd
i_link  input  1  1 = JAL/JALR link: result is i_pc8
i_link_ra  input  1  1 = link destination is register 31 (JAL)
i_fwd_a  input  2  forward select for rs
i_fwd_b  input  2  forward select for rt
i_exmem_fwd  input  NB_DATA  EX/MEM result forwarded back
i_memwb_fwd  input  NB_DATA  MEM/WB writeback value
i_width, i_sign_flag, i_mem2reg, i_memWrite, i_regWrite  input  2,1,1,1,1  control signals passed through
o_result  output  NB_DATA  registered ALU/link result (memory address for loads and stores)
o_data4Mem  output  NB_DATA  registered forwarded rt (store data)
o_write_reg  output  NB_REG  registered destination index
o_width, o_sign_flag, o_mem2reg, o_memWrite, o_regWrite  output  2,1,1,1,1  registered control signals

Behaviour:
- Reset: i_rst_n low clears every output to 0, immediately (asynchronous).
- Latency: 1 cycle; inputs are sampled at the posedge of clk and appear at the outputs after that edge.
- Forwarding, operand A from i_fwd_a: 00 = i_rs_data, 01 = i_memwb_fwd, 10 = i_exmem_fwd, 11 = i_rs_data.
- Forwarding, forwarded rt (fwd_b) from i_fwd_b: same encoding, applied to i_rt_data.
- Operand B = i_alu_src ? i_imm : fwd_b.
- o_data4Mem always takes fwd_b, never imm.
- ALU operations, by i_alu_ctrl value:
  - 0 ADD, 1 SUB: modulo 2^32, no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed compare), 7 SLTU (unsigned compare); result is 0 or 1.
  - 8 SLL B<<shamt, 9 SRL, 10 SRA.
  - 11 SLLV B<<A[4:0], 12 SRLV, 13 SRAV.
  - 14 LUI: {B[15:0], 16'b0}.
  - 15: result 0.
- Result = i_link ? i_pc8 : alu_out.
- Destination = i_link_ra ? 31 : (i_reg_dst ? i_rd_addr : i_rt_addr).
- Cycle-edge priority:
  - Reset first.
  - i_halt: hold all outputs.
  - i_flush: bubble, i.e. all outputs 0, including regWrite and memWrite.
  - Otherwise load the new values.
- i_halt and i_flush both high: halt wins; flush has no effect that cycle.
- Forwarded values are used combinationally in the same cycle; there is no internal forwarding state.
- Shift amounts use only 5 bits; register-amount shifts ignore A[31:5].

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD … ALU_LUI), forward-select constants (FWD_REG = 00, FWD_MEMWB = 01, FWD_EXMEM = 10), and REG_RA = 31.
- One combinational sub-module, alu (inputs A, B, shamt, ctrl; output result). The forwarding muxes and the pipeline register stay in execute_stage.

Test Plan:
- ADD with i_fwd_a = 10, i_exmem_fwd = 5, i_rt_data = 7, i_reg_dst = 1, rd = 9 -> next cycle o_result = 12, o_write_reg = 9.
- SLT vs SLTU with A = 0xFFFFFFFF, B = 1 -> SLT o_result = 1; SLTU o_result = 0.
- SRA, shamt = 4, B = 0x80000000 -> o_result = 0xF8000000. SRAV with A = 0x24 -> shift by 4, same result.
- SW, alu_src = 1, imm = 8, rs = 0x10, i_fwd_b = 01, i_memwb_fwd = 0xDEAD -> o_result = 0x18, o_data4Mem = 0xDEAD, o_memWrite = 1.
- JAL, i_link = i_link_ra = 1, i_pc8 = 0x40 -> o_result = 0x40, o_write_reg = 31. Then halt for 3 cycles with changed inputs -> outputs unchanged.
- Flush while o_regWrite = 1 -> next cycle all outputs 0. Halt and flush together -> outputs held. Assert reset mid-stream -> outputs 0 immediately, without waiting for a clock edge.
